// File: rtl/core_pkg.sv
// core_pkg: defaults shared with the MAC array and a pointer-width helper.
package core_pkg;
    localparam int PSUM_BW = 16;
    localparam int COL = 8;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/ofifo_collector_if.sv
// ofifo_collector_if: array-side write bus and downstream row-pop bus of the collector.
interface ofifo_collector_if import core_pkg::*; #(
    parameter int psum_bw = PSUM_BW,
    parameter int col = COL
);
    logic [psum_bw*col-1:0] in;
    logic [col-1:0] wr;
    logic rd;
    logic [psum_bw*col-1:0] out;
    logic o_valid;
    logic o_full;
    logic o_ready;
    logic out_strobe;
    logic overflow;
    modport master(output in, wr, rd, input out, o_valid, o_full, o_ready, out_strobe, overflow);
    modport slave(input in, wr, rd, output out, o_valid, o_full, o_ready, out_strobe, overflow);
endinterface

// File: rtl/col_fifo.sv
// col_fifo: single-column synchronous FIFO with wrap-bit pointers; a write to a full
// column is still accepted when the same cycle pops it.
module col_fifo import core_pkg::*; #(
    parameter int psum_bw = PSUM_BW,
    parameter int depth = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic wr,
    input  logic rd,
    input  logic [psum_bw-1:0] in,
    output logic [psum_bw-1:0] out,
    output logic empty,
    output logic full
);
    localparam int aw = clog2(depth);
    localparam logic [aw:0] one = {{aw{1'b0}}, 1'b1};
    logic [aw:0] wp_q, wp_d, rp_q, rp_d;
    logic [psum_bw-1:0] mem [depth];
    logic we;
    assign empty = wp_q == rp_q;
    assign full = (wp_q[aw-1:0] == rp_q[aw-1:0]) && (wp_q[aw] != rp_q[aw]);
    assign out = mem[rp_q[aw-1:0]];
    always_comb begin
        we = wr && (!full || rd);
        wp_d = we ? wp_q + one : wp_q;
        rp_d = rd ? rp_q + one : rp_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end
    always_ff @(posedge clk) begin
        if (we) mem[wp_q[aw-1:0]] <= in;
    end
endmodule

// File: rtl/ofifo_collector.sv
// ofifo_collector: per-column FIFOs realigning the skewed south-edge psums into whole rows.
module ofifo_collector import core_pkg::*; #(
    parameter int psum_bw = PSUM_BW,
    parameter int col = COL,
    parameter int depth = 64
) (
    input logic clk,
    input logic reset,
    ofifo_collector_if.slave bus
);
    logic [col-1:0] empty, full;
    logic [psum_bw*col-1:0] head, out_q, out_d;
    logic valid, pop, strobe_q, strobe_d, ovf_q, ovf_d;
    for (genvar c = 0; c < col; c++) begin : g_col
        col_fifo #(.psum_bw(psum_bw), .depth(depth)) u_fifo (
            .clk(clk),
            .reset(reset),
            .wr(bus.wr[c]),
            .rd(pop),
            .in(bus.in[psum_bw*c +: psum_bw]),
            .out(head[psum_bw*c +: psum_bw]),
            .empty(empty[c]),
            .full(full[c])
        );
    end
    // All columns pop together so rows can never slip out of alignment.
    always_comb begin
        valid = &(~empty);
        pop = bus.rd && valid;
        out_d = pop ? head : out_q;
        strobe_d = pop;
        ovf_d = ovf_q || |(bus.wr & full & {col{!pop}});
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            strobe_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            strobe_q <= strobe_d;
            ovf_q <= ovf_d;
        end
    end
    assign bus.out = out_q;
    assign bus.o_valid = valid;
    assign bus.o_full = |full;
    assign bus.o_ready = ~|full;
    assign bus.out_strobe = strobe_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_ofifo_collector.sv
// tb_ofifo_collector: directed scenarios against a per-column queue model; popped rows
// are queued as expectations and retired when the DUT presents them.
module tb_ofifo_collector;
    localparam int W = 16;
    localparam int C = 8;
    localparam int D = 64;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    ofifo_collector_if #(.psum_bw(W), .col(C)) bus();
    ofifo_collector #(.psum_bw(W), .col(C), .depth(D)) dut (.clk(clk), .reset(reset), .bus(bus));
    logic [W-1:0] mm [C][D];
    int wp [C];
    int rp [C];
    int cnt [C];
    logic [W*C-1:0] exp_q [$];
    logic [W*C-1:0] last_out;
    logic m_ovf, m_strobe;
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [W*C-1:0] row(input int base);
        logic [W*C-1:0] r;
        for (int c = 0; c < C; c++) r[W*c +: W] = W'(base + c);
        return r;
    endfunction

    task automatic check(input string tag);
        logic mv, mf;
        logic [4:0] e, a;
        mv = 1'b1;
        mf = 1'b0;
        for (int c = 0; c < C; c++) begin
            if (cnt[c] == 0) mv = 1'b0;
            if (cnt[c] == D) mf = 1'b1;
        end
        e = {mv, mf, !mf, m_ovf, m_strobe};
        a = {bus.o_valid, bus.o_full, bus.o_ready, bus.overflow, bus.out_strobe};
        n_cmp++;
        assert (a === e) else begin
            n_bad++;
            $error("FAIL %s flags{valid,full,ready,ovf,strobe} got=%b exp=%b", tag, a, e);
        end
        n_cmp++;
        assert (bus.out === last_out) else begin
            n_bad++;
            $error("FAIL %s out got=%h exp=%h", tag, bus.out, last_out);
        end
    endtask

    task automatic step(input logic [C-1:0] w, input int base, input logic r, input string tag);
        logic mv, pop;
        logic [W*C-1:0] h;
        mv = 1'b1;
        for (int c = 0; c < C; c++) if (cnt[c] == 0) mv = 1'b0;
        pop = r && mv;
        bus.wr = w;
        bus.in = row(base);
        bus.rd = r;
        if (pop) begin
            for (int c = 0; c < C; c++) h[W*c +: W] = mm[c][rp[c]];
            exp_q.push_back(h);
        end
        for (int c = 0; c < C; c++) begin
            if (w[c] && (cnt[c] < D || pop)) begin
                mm[c][wp[c]] = W'(base + c);
                wp[c] = (wp[c] + 1) % D;
                cnt[c]++;
            end else if (w[c]) m_ovf = 1'b1;
            if (pop) begin
                rp[c] = (rp[c] + 1) % D;
                cnt[c]--;
            end
        end
        @(posedge clk);
        #1;
        bus.wr = '0;
        bus.rd = 1'b0;
        m_strobe = pop;
        if (pop) last_out = exp_q.pop_front();
        check(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.wr = '0;
        bus.rd = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < C; c++) begin
            wp[c] = 0;
            rp[c] = 0;
            cnt[c] = 0;
        end
        exp_q.delete();
        last_out = '0;
        m_ovf = 1'b0;
        m_strobe = 1'b0;
        check("reset");
    endtask

    initial begin
        reset = 1'b1;
        bus.wr = '0;
        bus.rd = 1'b0;
        bus.in = '0;
        @(posedge clk);
        do_reset();
        for (int c = 0; c < C; c++) step(C'(1) << c, 16'h0100, 1'b0, "skew_fill");
        step('0, 0, 1'b1, "skew_pop");
        step('0, 0, 1'b0, "skew_idle");
        for (int i = 0; i < 132; i++) step(i < 128 ? '1 : '0, 16'h1000 + i * 8, 1'b1, "stream");
        for (int i = 0; i < D; i++) step(8'h08, i * 8, 1'b0, "fill_col3");
        step(8'h08, 16'h7777, 1'b0, "overflow_col3");
        for (int i = 0; i < D; i++) step(8'hF7, 16'h3000 + i * 8, 1'b0, "fill_rest");
        for (int i = 0; i < D + 2; i++) step('0, 0, 1'b1, "drain_col3");
        do_reset();
        for (int i = 0; i < D; i++) step('1, 16'h4000 + i * 8, 1'b0, "fill_all");
        step('1, 16'h5000, 1'b1, "full_wr_pop");
        for (int i = 0; i < D + 1; i++) step('0, 0, 1'b1, "drain_all");
        do_reset();
        for (int i = 0; i < 5; i++) step('0, 0, 1'b1, "underflow");
        step('1, 16'h6000, 1'b0, "post_under_fill");
        step('0, 0, 1'b1, "post_under_pop");
        for (int i = 0; i < 20; i++) step('1, 16'h7000 + i * 8, 1'b0, "pre_reset_fill");
        do_reset();
        step('1, 16'h2000, 1'b0, "post_reset_fill");
        step('0, 0, 1'b1, "post_reset_pop");
        step('0, 0, 1'b1, "post_reset_empty");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
